// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller.
//   state_t  : controller FSM states
//   FWD_*    : ALU operand source select encodings
//   NOP      : instruction word loaded into IF/ID on a flush
package pipe_ctrl_pkg;

    localparam int REG_W = 4;
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        FLUSH = 3'd1,
        MWAIT = 3'd2,
        DRAIN = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    localparam logic [15:0] NOP = 16'h0000;

endpackage

// File: rtl/pipe_ctrl_hazard_cmp.sv
// pipe_ctrl_hazard_cmp: combinational source/destination register match for one operand.
//   i_src, i_re : source register and its read-enable
//   i_dst, i_we : destination register and its write-enable
//   o_match     : source depends on destination (register 0 excluded when ZERO_REG=1)
module pipe_ctrl_hazard_cmp
    import pipe_ctrl_pkg::*;
#(
    parameter int ZERO_REG = 1
) (
    input  logic [REG_W-1:0] i_src,
    input  logic             i_re,
    input  logic [REG_W-1:0] i_dst,
    input  logic             i_we,
    output logic             o_match
);

    logic w_zero;

    assign w_zero  = (ZERO_REG != 0) && (i_dst == '0);
    assign o_match = i_re & i_we & (i_src == i_dst) & ~w_zero;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/forwarding controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_id_*                  : ID source registers, read-enables, HLT flag
//   i_ex_*, i_mem_*         : EX/MEM destination registers, write-enables, EX load flag
//   i_br_taken, i_dm_busy   : taken branch resolved in EX, data memory not ready
//   o_pc_hold, o_ifid_hold  : hold PC / IF-ID register
//   o_ifid_flush, o_idex_flush : load NOP into IF-ID / bubble into ID-EX
//   o_pipe_freeze           : all pipeline registers hold
//   o_fwd_a, o_fwd_b        : registered ALU operand source selects
//   o_halted                : pipeline drained after HLT
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int BR_PENALTY = 2,
    parameter int DRAIN_CYC  = 3,
    parameter int ZERO_REG   = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_re0,
    input  logic             i_id_re1,
    input  logic             i_id_hlt,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_ex_we,
    input  logic             i_ex_load,
    input  logic [REG_W-1:0] i_mem_rd,
    input  logic             i_mem_we,
    input  logic             i_br_taken,
    input  logic             i_dm_busy,
    output logic             o_pc_hold,
    output logic             o_ifid_hold,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_pipe_freeze,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic             o_halted
);

    logic             w_ma_ex, w_mb_ex, w_ma_mem, w_mb_mem;
    logic             w_br, w_lu;
    logic [1:0]       w_fa, w_fb;
    state_t           r_state, r_ret, w_cur, w_nstate, w_nret;
    logic [CNT_W-1:0] r_cnt, w_ncnt;
    logic             r_brp, w_nbrp;
    logic [1:0]       r_fwd_a, r_fwd_b;
    logic             w_pc_hold, w_ifid_hold, w_ifid_flush, w_idex_flush, w_freeze, w_halted;

    pipe_ctrl_hazard_cmp #(.ZERO_REG(ZERO_REG)) u_a_ex (
        .i_src(i_id_rs), .i_re(i_id_re0), .i_dst(i_ex_rd), .i_we(i_ex_we), .o_match(w_ma_ex)
    );
    pipe_ctrl_hazard_cmp #(.ZERO_REG(ZERO_REG)) u_b_ex (
        .i_src(i_id_rt), .i_re(i_id_re1), .i_dst(i_ex_rd), .i_we(i_ex_we), .o_match(w_mb_ex)
    );
    pipe_ctrl_hazard_cmp #(.ZERO_REG(ZERO_REG)) u_a_mem (
        .i_src(i_id_rs), .i_re(i_id_re0), .i_dst(i_mem_rd), .i_we(i_mem_we), .o_match(w_ma_mem)
    );
    pipe_ctrl_hazard_cmp #(.ZERO_REG(ZERO_REG)) u_b_mem (
        .i_src(i_id_rt), .i_re(i_id_re1), .i_dst(i_mem_rd), .i_we(i_mem_we), .o_match(w_mb_mem)
    );

    // Leaving MWAIT, the saved state acts immediately, so the cycle after
    // dm_busy falls behaves exactly as the interrupted state would have.
    assign w_cur = (r_state == MWAIT) ? r_ret : r_state;
    assign w_br  = i_br_taken | r_brp;
    assign w_lu  = i_ex_load & (w_ma_ex | w_mb_ex);
    assign w_fa  = (w_ma_ex & ~i_ex_load) ? FWD_EXMEM : w_ma_mem ? FWD_MEMWB : FWD_RF;
    assign w_fb  = (w_mb_ex & ~i_ex_load) ? FWD_EXMEM : w_mb_mem ? FWD_MEMWB : FWD_RF;

    always_comb begin
        w_pc_hold    = 1'b0;
        w_ifid_hold  = 1'b0;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        w_freeze     = 1'b0;
        w_halted     = 1'b0;
        w_nstate     = w_cur;
        w_nret       = r_ret;
        w_ncnt       = r_cnt;
        w_nbrp       = 1'b0;
        if (w_cur == HALT) begin
            w_halted     = 1'b1;
            w_pc_hold    = 1'b1;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end else if (i_dm_busy) begin
            w_freeze    = 1'b1;
            w_pc_hold   = 1'b1;
            w_ifid_hold = 1'b1;
            w_nstate    = MWAIT;
            w_nret      = w_cur;
            w_nbrp      = w_br;
        end else begin
            case (w_cur)
                FLUSH: begin
                    w_ifid_flush = 1'b1;
                    w_ncnt       = (r_cnt <= 1) ? '0 : r_cnt - 1'b1;
                    w_nstate     = (r_cnt <= 1) ? RUN : FLUSH;
                end
                DRAIN: begin
                    w_pc_hold    = 1'b1;
                    w_ifid_flush = 1'b1;
                    w_ncnt       = (r_cnt <= 1) ? '0 : r_cnt - 1'b1;
                    w_nstate     = (r_cnt <= 1) ? HALT : DRAIN;
                end
                default: begin
                    if (w_br) begin
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                        w_ncnt       = CNT_W'(BR_PENALTY - 1);
                        w_nstate     = (BR_PENALTY > 1) ? FLUSH : RUN;
                    end else if (i_id_hlt) begin
                        w_ncnt   = CNT_W'(DRAIN_CYC);
                        w_nstate = DRAIN;
                    end else if (w_lu) begin
                        w_pc_hold    = 1'b1;
                        w_ifid_hold  = 1'b1;
                        w_idex_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RUN;
            r_ret   <= RUN;
            r_cnt   <= '0;
            r_brp   <= 1'b0;
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else begin
            r_state <= w_nstate;
            r_ret   <= w_nret;
            r_cnt   <= w_ncnt;
            r_brp   <= w_nbrp;
            // Forward selects travel with the ID/EX register: held on freeze, cleared with a bubble.
            if (!w_freeze) begin
                r_fwd_a <= w_idex_flush ? FWD_RF : w_fa;
                r_fwd_b <= w_idex_flush ? FWD_RF : w_fb;
            end
        end
    end

    // Gating with reset keeps every control low while reset is held, whatever the inputs do.
    assign o_pc_hold     = w_pc_hold & i_rst_n;
    assign o_ifid_hold   = w_ifid_hold & i_rst_n;
    assign o_ifid_flush  = w_ifid_flush & i_rst_n;
    assign o_idex_flush  = w_idex_flush & i_rst_n;
    assign o_pipe_freeze = w_freeze & i_rst_n;
    assign o_halted      = w_halted & i_rst_n;
    assign o_fwd_a       = r_fwd_a;
    assign o_fwd_b       = r_fwd_b;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed stimulus for pipe_ctrl, checked per cycle against a behavioural model plus literal expectations.
module tb_pipe_ctrl;

    localparam int BRP = 2;
    localparam int DRC = 3;
    localparam int ZR  = 1;

    logic       clk, rst_n;
    logic [3:0] id_rs, id_rt, ex_rd, mem_rd;
    logic       id_re0, id_re1, id_hlt, ex_we, ex_load, mem_we, br, busy;
    logic       pc_hold, ifid_hold, ifid_flush, idex_flush, freeze, halted;
    logic [1:0] fa, fb;
    logic [9:0] dut_vec;
    int         checks, failures, cyc;

    pipe_ctrl #(.BR_PENALTY(BRP), .DRAIN_CYC(DRC), .ZERO_REG(ZR)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_re0(id_re0), .i_id_re1(id_re1), .i_id_hlt(id_hlt),
        .i_ex_rd(ex_rd), .i_ex_we(ex_we), .i_ex_load(ex_load),
        .i_mem_rd(mem_rd), .i_mem_we(mem_we),
        .i_br_taken(br), .i_dm_busy(busy),
        .o_pc_hold(pc_hold), .o_ifid_hold(ifid_hold), .o_ifid_flush(ifid_flush),
        .o_idex_flush(idex_flush), .o_pipe_freeze(freeze),
        .o_fwd_a(fa), .o_fwd_b(fb), .o_halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dut_vec = {pc_hold, ifid_hold, ifid_flush, idex_flush, freeze, halted, fa, fb};

    // Model: remaining flush cycles, remaining drain cycles, halted flag, latched branch.
    int         m_flush, m_drain, n_flush, n_drain;
    logic       m_halt, m_pend, n_halt, n_pend;
    logic [1:0] m_fa, m_fb, n_fa, n_fb;
    logic       e_ph, e_ih, e_if, e_xf, e_fz, e_hl, brx, ld;
    logic [9:0] e_out;

    function automatic logic hit(input logic [3:0] s, input logic re, input logic [3:0] d, input logic we);
        return re && we && s == d && !(ZR != 0 && d == 4'd0);
    endfunction

    function automatic logic [1:0] fsel(input logic [3:0] s, input logic re, input logic [3:0] erd,
                                        input logic ewe, input logic eld, input logic [3:0] mrd, input logic mwe);
        if (hit(s, re, erd, ewe) && !eld) return 2'd1;
        if (hit(s, re, mrd, mwe)) return 2'd2;
        return 2'd0;
    endfunction

    always_comb begin
        {e_ph, e_ih, e_if, e_xf, e_fz, e_hl} = '0;
        n_flush = m_flush;
        n_drain = m_drain;
        n_halt  = m_halt;
        n_pend  = m_pend;
        brx     = br | m_pend;
        ld      = ex_load && (hit(id_rs, id_re0, ex_rd, ex_we) || hit(id_rt, id_re1, ex_rd, ex_we));
        if (m_halt) begin
            {e_hl, e_ph, e_if, e_xf} = 4'hf;
        end else if (busy) begin
            {e_fz, e_ph, e_ih} = 3'b111;
            n_pend = brx;
        end else begin
            n_pend = 1'b0;
            if (m_flush > 0) begin
                e_if = 1'b1;
                n_flush = m_flush - 1;
            end else if (m_drain > 0) begin
                {e_ph, e_if} = 2'b11;
                n_drain = m_drain - 1;
                n_halt = (m_drain == 1);
            end else if (brx) begin
                {e_if, e_xf} = 2'b11;
                n_flush = BRP - 1;
            end else if (id_hlt) begin
                n_drain = DRC;
            end else if (ld) begin
                {e_ph, e_ih, e_xf} = 3'b111;
            end
        end
        n_fa  = e_fz ? m_fa : e_xf ? 2'd0 : fsel(id_rs, id_re0, ex_rd, ex_we, ex_load, mem_rd, mem_we);
        n_fb  = e_fz ? m_fb : e_xf ? 2'd0 : fsel(id_rt, id_re1, ex_rd, ex_we, ex_load, mem_rd, mem_we);
        e_out = {e_ph, e_ih, e_if, e_xf, e_fz, e_hl, m_fa, m_fb};
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_flush <= 0; m_drain <= 0; m_halt <= 1'b0; m_pend <= 1'b0; m_fa <= 2'd0; m_fb <= 2'd0;
        end else begin
            m_flush <= n_flush; m_drain <= n_drain; m_halt <= n_halt; m_pend <= n_pend;
            m_fa <= n_fa; m_fb <= n_fb;
        end
    end

    task automatic chk(input string nm, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    // Compares the finishing cycle against the model, then starts a new cycle with idle inputs.
    task automatic go();
        @(negedge clk);
        if (rst_n) begin
            checks++;
            if (dut_vec !== e_out) begin
                failures++;
                $display("FAIL model cyc=%0d got=%b exp=%b", cyc, dut_vec, e_out);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        {id_rs, id_rt, id_re0, id_re1, id_hlt, ex_rd, ex_we, ex_load, mem_rd, mem_we, br, busy} = '0;
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        rst_n = 1'b0;
        {id_rs, id_rt, id_re0, id_re1, id_hlt, ex_rd, ex_we, ex_load, mem_rd, mem_we, br, busy} = '0;
        busy = 1'b1; id_hlt = 1'b1;
        #12;
        chk("reset_outputs", dut_vec, 10'd0);
        go(); rst_n = 1'b1; #2;
        chk("post_reset", dut_vec, 10'd0);

        // load-use on R3, then MEM forward
        go(); ex_load = 1; ex_we = 1; ex_rd = 3; id_rs = 3; id_re0 = 1; #2;
        chk("lu_pc_hold", 10'(pc_hold), 10'd1);
        chk("lu_ifid_hold", 10'(ifid_hold), 10'd1);
        chk("lu_idex_flush", 10'(idex_flush), 10'd1);
        chk("lu_ifid_flush", 10'(ifid_flush), 10'd0);
        go(); mem_we = 1; mem_rd = 3; id_rs = 3; id_re0 = 1; #2;
        chk("lu_resolved", 10'(pc_hold), 10'd0);
        go(); #2;
        chk("lu_fwd_a", 10'(fa), 10'd2);
        chk("lu_fwd_b", 10'(fb), 10'd0);

        // EX forward on both ports, then R0, then mixed, then EX-over-MEM priority
        go(); ex_we = 1; ex_rd = 5; id_rs = 5; id_rt = 5; id_re0 = 1; id_re1 = 1; #2;
        chk("r5_no_stall", 10'(pc_hold), 10'd0);
        go(); ex_we = 1; ex_load = 1; ex_rd = 0; mem_we = 1; mem_rd = 0; id_re0 = 1; id_re1 = 1; #2;
        chk("r5_fwd", {6'd0, fa, fb}, 10'b0101);
        chk("r0_no_stall", 10'(pc_hold), 10'd0);
        go(); ex_we = 1; ex_rd = 4; mem_we = 1; mem_rd = 6; id_rs = 4; id_rt = 6; id_re0 = 1; id_re1 = 1; #2;
        chk("r0_fwd", {6'd0, fa, fb}, 10'd0);
        go(); ex_we = 1; ex_rd = 7; mem_we = 1; mem_rd = 7; id_rt = 7; id_re1 = 1; #2;
        chk("mixed_fwd", {6'd0, fa, fb}, 10'b0110);
        go(); #2;
        chk("prio_fwd", {6'd0, fa, fb}, 10'b0001);

        // taken branch overriding a load-use stall
        go(); br = 1; ex_load = 1; ex_we = 1; ex_rd = 2; id_rs = 2; id_re0 = 1; #2;
        chk("br_flushes", {8'd0, ifid_flush, idex_flush}, 10'b11);
        chk("br_over_lu", 10'(pc_hold), 10'd0);
        go(); #2;
        chk("flush_cyc2", {8'd0, ifid_flush, idex_flush}, 10'b10);
        go(); #2;
        chk("flush_done", 10'(ifid_flush), 10'd0);

        // dm_busy for 4 cycles with one flush cycle outstanding
        go(); br = 1; #2;
        for (int i = 0; i < 4; i++) begin
            go(); busy = 1; #2;
            chk("mw_freeze", {8'd0, freeze, ifid_flush}, 10'b10);
        end
        go(); #2;
        chk("mw_resume", {8'd0, freeze, ifid_flush}, 10'b01);
        go(); #2;
        chk("mw_done", 10'(ifid_flush), 10'd0);

        // branch coincident with dm_busy is serviced afterwards
        go(); br = 1; busy = 1; #2;
        chk("brbusy_freeze", {8'd0, freeze, idex_flush}, 10'b10);
        go(); #2;
        chk("brbusy_exit", {8'd0, ifid_flush, idex_flush}, 10'b11);
        go(); #2;
        chk("brbusy_flush", {8'd0, ifid_flush, idex_flush}, 10'b10);
        go(); #2;
        chk("brbusy_done", 10'(ifid_flush), 10'd0);

        // HLT on a wrong path is squashed
        go(); id_hlt = 1; br = 1; #2;
        chk("hltbr_flush", 10'(idex_flush), 10'd1);
        for (int i = 0; i < 5; i++) begin
            go(); #2;
            chk("hltbr_no_halt", {8'd0, halted, pc_hold}, 10'd0);
        end

        // HLT drain and halt
        go(); id_hlt = 1; #2;
        chk("hlt_cycle", {8'd0, pc_hold, ifid_flush}, 10'd0);
        for (int i = 0; i < DRC; i++) begin
            go(); #2;
            chk("drain", {7'd0, pc_hold, ifid_flush, halted}, 10'b110);
        end
        go(); busy = 1; #2;
        chk("halted", {7'd0, halted, freeze, idex_flush}, 10'b101);
        go(); #2;
        chk("halt_stays", 10'(halted), 10'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset", dut_vec, 10'd0);
        go(); rst_n = 1'b1; #2;
        chk("after_halt_reset", dut_vec, 10'd0);
        go(); ex_we = 1; ex_rd = 9; id_rs = 9; id_re0 = 1; #2;
        go(); #2;
        chk("run_after_reset", 10'(fa), 10'd1);
        go();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Hazard and sequencing controller for the 5-stage IF/ID/EX/MEM/WB pipeline. It replaces the hard-tied PC hold with real stall, flush and forwarding control. It detects load-use hazards, squashes wrong-path instructions after a taken branch, freezes the pipe while data memory is busy, and drains the pipe to a halted state on HLT. Sits beside the datapath. Consumes decoded register fields from ID/EX/MEM and drives the pipeline-register enables and clears.

Parameters:
BR_PENALTY, 2, number of younger instructions squashed after a taken branch resolved in EX (1..3)
DRAIN_CYC, 3, cycles to retire in-flight instructions after HLT leaves ID
ZERO_REG, 1, when 1, register 0 never creates a hazard or forward

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  reset, asynchronous, active-low
id_rs  in  4  ID source register A
id_rt  in  4  ID source register B
id_re0  in  1  ID reads register A
id_re1  in  1  ID reads register B
id_hlt  in  1  ID holds an HLT instruction
ex_rd  in  4  EX destination register
ex_we  in  1  EX writes register file
ex_load  in  1  EX instruction is a load
mem_rd  in  4  MEM destination register
mem_we  in  1  MEM writes register file
br_taken  in  1  taken branch/jump resolved in EX (1-cycle pulse)
dm_busy  in  1  data memory not ready this cycle
pc_hold  out  1  PC keeps its value
ifid_hold  out  1  IF/ID register keeps its value
ifid_flush  out  1  IF/ID loads NOP (instr 16'h0000)
idex_flush  out  1  ID/EX loads bubble
pipe_freeze  out  1  all pipeline registers hold
fwd_a  out  2  ALU A source: 0 = RF, 1 = EX/MEM result, 2 = MEM/WB writeback
fwd_b  out  2  ALU B source, same encoding
halted  out  1  pipeline drained after HLT

Behaviour:
- Registered FSM states: RUN, FLUSH, MWAIT, DRAIN, HALT. Reset (rst=0) forces RUN with counter 0. The FSM, counter and fwd registers are the only flops.
- Reset values: all outputs 0, fwd_a = fwd_b = 0.
- Control outputs are combinational from the current state and inputs. They take effect on the same clock edge.
- Hazard match: src valid (re=1) and src == dest and dest we=1. When ZERO_REG=1, dest 0 is excluded.
- Load-use (RUN only): match against EX with ex_load=1. Assert pc_hold, ifid_hold and idex_flush for exactly 1 cycle. No state change. The next cycle resolves via forwarding from MEM.
- Forwarding: fwd_x is registered. It is computed at the ID→EX edge and held with ID/EX. An EX match that is not a load gives 1, else a MEM match gives 2, else 0. EX has priority over MEM. While idex_flush=1, fwd is loaded 0.
- br_taken in RUN: assert ifid_flush and idex_flush this cycle. Load the counter with BR_PENALTY-1. Go to FLUSH if the counter is nonzero. FLUSH keeps asserting ifid_flush and decrements; it returns to RUN at 0. br_taken overrides a simultaneous load-use stall.
- dm_busy=1 in any state except HALT: pipe_freeze=1, pc_hold=1, ifid_hold=1, no flushes. Enter MWAIT, saving the return state and counter. When dm_busy falls, resume the saved state the next cycle with the counter unchanged. A br_taken pulse coincident with dm_busy is latched and serviced on exit.
- id_hlt in RUN, with no flush pending: pc_hold=1 and ifid_flush=1 from the next cycle. Load the counter with DRAIN_CYC and go to DRAIN. DRAIN decrements each non-frozen cycle and goes to HALT at 0.
- HALT: halted=1, pc_hold=1, ifid_flush=1, idex_flush=1. Only reset exits.
- HLT on a wrong path is squashed when id_hlt and br_taken are asserted in the same cycle; the branch wins.
- Priority: HALT > dm_busy > br_taken/FLUSH > id_hlt > load-use > normal.
- Reset asserted mid-FLUSH, MWAIT or DRAIN returns to RUN immediately and deasserts all outputs asynchronously.

Decomposition:
- Shared package/header (alongside opcode.h): FSM state encodings, FWD_RF/FWD_EXMEM/FWD_MEMWB constants, NOP encoding 16'h0000.
- One sub-module, hazard_cmp: purely combinational source/dest match for one operand. Instantiated twice for EX and twice for MEM.

Test Plan:
- LW R3 in EX (ex_load=1, ex_rd=3, ex_we=1) with ID ADD reading R3 (id_re0=1) -> one cycle of pc_hold=ifid_hold=idex_flush=1, then fwd_a=2 for the ADD in EX.
- ADD R5 in EX (ex_we=1, ex_rd=5, not a load), ID reads R5 on both ports -> no stall; fwd_a=fwd_b=1 next cycle. Same test with R0 and ZERO_REG=1 -> fwd=0.
- br_taken pulse with BR_PENALTY=2 -> ifid_flush=1 for 2 cycles, idex_flush=1 for 1 cycle, state back to RUN after 2 cycles.
- dm_busy held 4 cycles during FLUSH (counter 1) -> pipe_freeze=1 for exactly 4 cycles, then the remaining flush cycle completes.
- id_hlt with DRAIN_CYC=3 -> halted rises on the 4th cycle and stays high. Asserting rst=0 clears halted asynchronously.
- id_hlt together with br_taken -> HLT squashed, halted stays 0, normal flush sequence.
